// File: rtl/transpad_pkg.sv
// rtl/transpad_pkg.sv - shared command codes and arbiter state type for transpad_arb
package transpad_pkg;

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_STOP = 3'b111;

   typedef enum logic {IDLE, OWN} arb_state_t;

endpackage

// File: rtl/transpad_rr_pick.sv
// rtl/transpad_rr_pick.sv - combinational round-robin picker: first set req at or after ptr
module transpad_rr_pick
#(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
)
(
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      logic [IW-1:0] j;
      j   = '0;
      idx = '0;
      any = 1'b0;
      // Walk offsets downward so the smallest offset from ptr is the last one written.
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = IW'((int'(ptr) + i) % NREQ);
         if (req[j]) begin
            idx = j;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/transpad_arb.sv
// rtl/transpad_arb.sv - session arbiter for one transpad among NREQ requesters; TRANSPAD_ARB_WDOG_EN adds idle watchdog
module transpad_arb
   import transpad_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int CMDW    = 3,
   parameter int DATAW   = 48,
   parameter int TIMEOUT = 1024
)
(
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         lock,
   input  logic [NREQ*CMDW-1:0]    cmd_in,
   input  logic [NREQ*DATAW-1:0]   data_in,
   output logic [NREQ-1:0]         gnt,
   output logic [CMDW-1:0]         tp_cmd,
   output logic [DATAW-1:0]        tp_data,
   input  logic                    tp_rdy,
   output logic [$clog2(NREQ)-1:0] owner,
   output logic                    owner_vld
`ifdef TRANSPAD_ARB_WDOG_EN
   ,
   output logic                    wdog_o
`endif
);

   localparam int IW = $clog2(NREQ);

   arb_state_t       state, state_nxt;
   logic [IW-1:0]    rr_ptr, pick_idx, ptr_after;
   logic             pick_any, gnt_any, release_c, wdog_fire;
   logic             own_req, own_lock;
   logic [CMDW-1:0]  own_cmd;
   logic [DATAW-1:0] own_data;

   transpad_rr_pick #(.NREQ(NREQ)) u_pick (
      .req (req),
      .ptr (rr_ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      own_req  = 1'b0;
      own_lock = 1'b0;
      own_cmd  = '0;
      own_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (owner == IW'(i)) begin
            own_req  = req[i];
            own_lock = lock[i];
            own_cmd  = cmd_in[i*CMDW +: CMDW];
            own_data = data_in[i*DATAW +: DATAW];
         end
      end
   end

   // Masked by rstn so a reset cycle never shows a grant, even mid-session.
   assign gnt_any   = rstn && (state == OWN) && own_req && tp_rdy;
   assign release_c = (state == OWN) && !own_lock && (!own_req || gnt_any);
   assign ptr_after = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;

`ifdef TRANSPAD_ARB_WDOG_EN
   logic [15:0] idle_cnt;

   assign wdog_fire = (state == OWN) && (idle_cnt == 16'(TIMEOUT - 1)) && tp_rdy && !gnt_any;

   always_ff @(posedge clk) begin
      if (!rstn || state != OWN || gnt_any) begin
         idle_cnt <= '0;
      end else if (idle_cnt != 16'(TIMEOUT - 1)) begin
         idle_cnt <= idle_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) wdog_o <= 1'b0;
      else       wdog_o <= wdog_fire;
   end
`else
   assign wdog_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick_any) state_nxt = OWN;
         OWN:     if (release_c || wdog_fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gnt = '0;
      gnt[owner] = gnt_any;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr    <= '0;
         owner     <= '0;
         owner_vld <= 1'b0;
         tp_cmd    <= CMDW'(CMD_NOP);
         tp_data   <= '0;
      end else begin
         tp_cmd <= CMDW'(CMD_NOP);
         if (state == IDLE) begin
            if (pick_any) owner <= pick_idx;
            owner_vld <= pick_any;
         end else begin
            if (wdog_fire) begin
               tp_cmd  <= CMDW'(CMD_STOP);
               tp_data <= '0;
            end else if (gnt_any) begin
               tp_cmd  <= own_cmd;
               tp_data <= own_data;
            end
            if (release_c || wdog_fire) begin
               rr_ptr    <= ptr_after;
               owner_vld <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_transpad_arb.sv
// tb/tb_transpad_arb.sv - table-driven bench with tp_cmd/tp_data scoreboard; watchdog case under TRANSPAD_ARB_WDOG_EN
module tb_transpad_arb;

   localparam int NREQ  = 4;
   localparam int CMDW  = 3;
   localparam int DATAW = 48;

   logic                   clk = 1'b0;
   logic                   rstn;
   logic [NREQ-1:0]        req, lock, gnt;
   logic [NREQ*CMDW-1:0]   cmd_in;
   logic [NREQ*DATAW-1:0]  data_in;
   logic [CMDW-1:0]        tp_cmd;
   logic [DATAW-1:0]       tp_data;
   logic                   tp_rdy;
   logic [1:0]             owner;
   logic                   owner_vld;
`ifdef TRANSPAD_ARB_WDOG_EN
   logic                   wdog_o;
`endif

   transpad_arb #(.NREQ(NREQ), .CMDW(CMDW), .DATAW(DATAW), .TIMEOUT(8)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .lock      (lock),
      .cmd_in    (cmd_in),
      .data_in   (data_in),
      .gnt       (gnt),
      .tp_cmd    (tp_cmd),
      .tp_data   (tp_data),
      .tp_rdy    (tp_rdy),
      .owner     (owner),
      .owner_vld (owner_vld)
`ifdef TRANSPAD_ARB_WDOG_EN
      ,
      .wdog_o    (wdog_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rstn;
      logic [3:0] req;
      logic [3:0] lock;
      logic       rdy;
      logic [3:0] gnt;
      logic       vld;
      logic [1:0] own;
   } vec_t;

   typedef struct {
      logic [2:0]  cmd;
      logic [47:0] data;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   logic [47:0] exp_data;

   function automatic logic [2:0] cmd_of(int k, int i);
      return 3'(((k + i) % 7) + 1);
   endfunction

   function automatic logic [47:0] data_of(int k, int i);
      return 48'(k * 256 + i + 1);
   endfunction

   task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic rd,
                      input logic [3:0] g, input logic v, input logic [1:0] o);
      vec_t x;
      x.rstn = r; x.req = rq; x.lock = lk; x.rdy = rd; x.gnt = g; x.vld = v; x.own = o;
      vecs.push_back(x);
   endtask

   task automatic drive_data(input int k);
      for (int i = 0; i < NREQ; i++) begin
         cmd_in[i*CMDW +: CMDW]    = cmd_of(k, i);
         data_in[i*DATAW +: DATAW] = data_of(k, i);
      end
   endtask

   task automatic sb_check(input int row);
      exp_t e;
      total++;
      if (sbq.size() == 0) begin
         bad++;
         $display("FAIL sb_empty row=%0d actual=0 required=1", row);
      end else begin
         total--;
         e = sbq.pop_front();
         chk("tp_cmd", row, 64'(tp_cmd), 64'(e.cmd));
         chk("tp_data", row, 64'(tp_data), 64'(e.data));
      end
   endtask

   initial begin
      exp_t e;
      int   w;

      // reset: random-looking req
      add(0, 4'b1011, 4'b0000, 1, 4'b0000, 0, 0);
      add(0, 4'b0110, 4'b0110, 1, 4'b0000, 0, 0);
      // session of requester 2, three commands
      add(1, 4'b0100, 4'b0100, 1, 4'b0000, 0, 0);
      add(1, 4'b0100, 4'b0100, 1, 4'b0100, 1, 2);
      add(1, 4'b0100, 4'b0100, 1, 4'b0100, 1, 2);
      add(1, 4'b0100, 4'b0000, 1, 4'b0100, 1, 2);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0);
      // fairness from rr_ptr=0
      add(0, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0001, 1, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0010, 1, 1);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0100, 1, 2);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b1000, 1, 3);
      add(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1111, 4'b0000, 1, 4'b0001, 1, 0);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0);
      // backpressure on owner 1, others' req ignored
      add(1, 4'b0010, 4'b0010, 0, 4'b0000, 0, 0);
      add(1, 4'b0010, 4'b0010, 0, 4'b0000, 1, 1);
      add(1, 4'b1111, 4'b0010, 0, 4'b0000, 1, 1);
      add(1, 4'b1111, 4'b0010, 0, 4'b0000, 1, 1);
      add(1, 4'b0010, 4'b0010, 0, 4'b0000, 1, 1);
      add(1, 4'b0010, 4'b0010, 0, 4'b0000, 1, 1);
      add(1, 4'b1010, 4'b0000, 1, 4'b0010, 1, 1);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0);
      // owner 3 locked idle, then reset mid-session
      add(1, 4'b1000, 4'b1000, 1, 4'b0000, 0, 0);
      add(1, 4'b0000, 4'b1000, 1, 4'b0000, 1, 3);
      add(1, 4'b0000, 4'b1000, 1, 4'b0000, 1, 3);
      add(0, 4'b1000, 4'b1000, 1, 4'b0000, 1, 3);
      add(1, 4'b1010, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1010, 4'b0000, 1, 4'b0010, 1, 1);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0);
      // lone requester 3: rr_ptr wraps, re-grant after one bubble
      add(1, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 3);
      add(1, 4'b1000, 4'b0000, 1, 4'b0000, 0, 0);
      add(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 3);
      add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0);

      rstn = 1'b0; req = '0; lock = '0; tp_rdy = 1'b0;
      drive_data(0);
      @(posedge clk); #1;
      e.cmd = 3'b000; e.data = '0; exp_data = '0;
      sbq.push_back(e);

      for (int k = 0; k < vecs.size(); k++) begin
         rstn = vecs[k].rstn; req = vecs[k].req; lock = vecs[k].lock; tp_rdy = vecs[k].rdy;
         drive_data(k);
         @(negedge clk);
         chk("gnt", k, 64'(gnt), 64'(vecs[k].gnt));
         chk("owner_vld", k, 64'(owner_vld), 64'(vecs[k].vld));
         if (vecs[k].vld) chk("owner", k, 64'(owner), 64'(vecs[k].own));
         sb_check(k);
         e.cmd = 3'b000;
         if (!vecs[k].rstn) begin
            exp_data = '0;
         end else begin
            for (int i = 0; i < NREQ; i++) begin
               if (vecs[k].gnt[i]) begin
                  e.cmd    = cmd_of(k, i);
                  exp_data = data_of(k, i);
               end
            end
         end
         e.data = exp_data;
         sbq.push_back(e);
         @(posedge clk); #1;
      end

      // hand sequence: owner 0 locked with no requests (rr_ptr is 0 here)
      w = vecs.size();
      req = 4'b0001; lock = 4'b0001; tp_rdy = 1'b1;
      @(negedge clk);
      chk("seq_gnt_arb", w, 64'(gnt), 64'd0);
      sb_check(w);
      @(posedge clk); #1;
      req = 4'b0000;
`ifdef TRANSPAD_ARB_WDOG_EN
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("wd_vld_hold", n, 64'(owner_vld), 64'd1);
         chk("wd_quiet", n, 64'(wdog_o), 64'd0);
         chk("wd_nop", n, 64'(tp_cmd), 64'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("wd_stop", w, 64'(tp_cmd), 64'(3'b111));
      chk("wd_data", w, 64'(tp_data), 64'd0);
      chk("wd_pulse", w, 64'(wdog_o), 64'd1);
      chk("wd_release", w, 64'(owner_vld), 64'd0);
      @(posedge clk); #1;
      lock = 4'b0000;
      @(negedge clk);
      chk("wd_pulse_end", w, 64'(wdog_o), 64'd0);
      chk("wd_nop_after", w, 64'(tp_cmd), 64'd0);
`else
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         chk("lock_hold_vld", n, 64'(owner_vld), 64'd1);
         chk("lock_hold_owner", n, 64'(owner), 64'd0);
         @(posedge clk); #1;
      end
      lock = 4'b0000;
      @(negedge clk);
      chk("unlock_vld", w, 64'(owner_vld), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("unlock_release", w, 64'(owner_vld), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
